hex_display_master: RTL and testbench
=====================================

Name: hex_display_master

Overview:
- Avalon-MM write master that pushes seven-segment codes into the per-digit HEX output PIO slaves of the timer-clock system.
- Takes packed BCD/hex digit values from the clock/timer datapath on a start strobe.
- Encodes each digit and writes only the digits whose code changed since the last write, unless forced.
- Removes the need for the Nios software loop to refresh HEX0..HEX5.

Parameters:
- NUM_DIGITS, 6, number of HEX PIO slaves driven (1..8).
- BASE_ADDR, 32'h0000_0000, byte address of digit 0 PIO data register.
- ADDR_STRIDE, 16, byte distance between consecutive digit PIOs.
- ACTIVE_LOW, 1, 1 = segment bits inverted (lit segment = 0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to refresh the display
- force  in  1  sampled with start; 1 = write every digit regardless of cache
- digits  in  4*NUM_DIGITS  digit i value in bits [4i+3:4i], 0x0..0xF
- blank  in  NUM_DIGITS  1 = digit i blanked (all segments off, dp included)
- dp  in  NUM_DIGITS  1 = decimal point of digit i lit
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse when a refresh completes
- avm_address  out  32  byte address of current write
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  {24'b0, seg code}
- avm_byteenable  out  4  constant 4'b0001 during writes
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: busy=0, done=0, avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, avm_byteenable=4'b0001. FSM goes to IDLE, digit index=0, pending=0. All cache entries are marked invalid.
- Encoding (active-high form, bit7=dp, bits6..0=g..a):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - dp sets bit7. Blank gives 00.
  - If ACTIVE_LOW=1, the byte is inverted: "0" no dp = C0, blank = FF.
- Latching: digits, blank, dp and force are registered on an accepted start. The cycle after, busy=1.
- FSM states:
  - IDLE: start -> latch inputs, index=0 -> SCAN.
  - SCAN (1 cycle per digit): compute code(index).
    - If force, or cache invalid, or code != cache[index]: drive address = BASE_ADDR + index*ADDR_STRIDE and writedata, assert avm_write -> WRITE.
    - Otherwise, if index = NUM_DIGITS-1 -> DONE; else index+1, stay in SCAN.
  - WRITE: hold address, writedata and write stable while avm_waitrequest=1. The transfer completes in the cycle with write=1 and waitrequest=0. On completion: cache[index]=code, valid; avm_write=0 next cycle; go to DONE if last digit, else index+1 -> SCAN.
  - DONE (1 cycle): done=1, busy=0 next cycle.
    - If pending=1, relatch from the pending registers, clear pending -> SCAN.
    - Otherwise -> IDLE.
- avm_write always drops for at least one cycle between transfers. No back-to-back writes.
- Latency with waitrequest tied 0: done asserts at cycle 1 + NUM_DIGITS + W after start, where W = number of digits written.
  - All-clean refresh: done at cycle 7 (NUM_DIGITS=6).
  - Full refresh: done at cycle 13.
- Start while busy (SCAN/WRITE/DONE): not dropped. Inputs are captured into pending registers and pending=1; a later start overwrites them (newest wins). Exactly one extra refresh runs after DONE. done pulses once per refresh.
- Start in the same cycle as DONE: treated as pending.
- Only the slave's data register (offset 0) is addressed. No reads are issued.
- Reset asserted mid-WRITE: avm_write goes to 0 at that edge regardless of waitrequest, and the cache is invalidated. The next refresh rewrites all digits.

Test Plan:
- Reset, waitrequest=0, start with digits=0x543210, dp=0, blank=0 -> six writes in order:
  - addr 0x00 C0, 0x10 F9, 0x20 A4, 0x30 B0, 0x40 99, 0x50 92 (byteenable 0001).
  - done at cycle 13, busy high cycles 1..12.
- Repeat identical start -> zero writes, done at cycle 7. Then digits=0x543219 -> exactly one write, addr 0x00 data 0x90.
- waitrequest held high 5 cycles on the digit 2 write -> address 0x20 and data A4 stable the whole time. Exactly one completed transfer, next write at 0x30 only after release.
- blank=6'b000010 and dp=6'b000001, force=1, digits=0 -> addr 0x00 data 0x40, addr 0x10 data 0xFF, others C0. All six written.
- During a refresh, pulse start with 0x111111, then 0x222222 -> second refresh uses 0x222222 (writes A4 to all digits), two done pulses total.
- Reset asserted in WRITE with waitrequest=1 -> avm_write=0 the next cycle, busy=0. The following start with unchanged digits rewrites all six.

Source files
------------

// File: rtl/hex_display_master.sv
// Avalon-MM write master that refreshes per-digit seven-segment HEX PIO slaves.
// Only digits whose code changed since the last completed write are written, unless forced.
module hex_display_master #(
    parameter int unsigned NumDigits  = 6,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int unsigned AddrStride = 16,
    parameter bit          ActiveLow  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     force_i,
    input  logic [4*NumDigits-1:0]   digits_i,
    input  logic [NumDigits-1:0]     blank_i,
    input  logic [NumDigits-1:0]     dp_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              avm_address_o,
    output logic                     avm_write_o,
    output logic [31:0]              avm_writedata_o,
    output logic [3:0]               avm_byteenable_o,
    input  logic                     avm_waitrequest_i
);

    localparam int unsigned IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDigits - 1);

    typedef enum logic [1:0] {StIdle, StScan, StWrite, StDone} state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        idx_q;
    logic                   busy_q, done_q, write_q;
    logic [31:0]            addr_q, wdata_q;

    logic [4*NumDigits-1:0] digits_q, pend_digits_q;
    logic [NumDigits-1:0]   blank_q, pend_blank_q;
    logic [NumDigits-1:0]   dp_q, pend_dp_q;
    logic                   force_q, pend_force_q, pending_q;

    logic [7:0]             cache_q [NumDigits];
    logic [NumDigits-1:0]   valid_q;

    logic [3:0]             cur_digit;
    logic                   cur_blank, cur_dp, cur_valid;
    logic [7:0]             cur_cache, seg_raw, seg;
    logic                   need_write;
    logic [31:0]            wr_addr;
    logic                   last_idx;

    always_comb begin
        cur_digit = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_valid = 1'b0;
        cur_cache = 8'h00;
        for (int i = 0; i < int'(NumDigits); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit = digits_q[4*i +: 4];
                cur_blank = blank_q[i];
                cur_dp    = dp_q[i];
                cur_valid = valid_q[i];
                cur_cache = cache_q[i];
            end
        end

        unique case (cur_digit)
            4'h0: seg_raw = 8'h3F;
            4'h1: seg_raw = 8'h06;
            4'h2: seg_raw = 8'h5B;
            4'h3: seg_raw = 8'h4F;
            4'h4: seg_raw = 8'h66;
            4'h5: seg_raw = 8'h6D;
            4'h6: seg_raw = 8'h7D;
            4'h7: seg_raw = 8'h07;
            4'h8: seg_raw = 8'h7F;
            4'h9: seg_raw = 8'h6F;
            4'hA: seg_raw = 8'h77;
            4'hB: seg_raw = 8'h7C;
            4'hC: seg_raw = 8'h39;
            4'hD: seg_raw = 8'h5E;
            4'hE: seg_raw = 8'h79;
            default: seg_raw = 8'h71;
        endcase

        // Blank overrides the decimal point as well as the digit segments.
        seg = cur_blank ? 8'h00 : {cur_dp, seg_raw[6:0]};
        if (ActiveLow) begin
            seg = ~seg;
        end

        need_write = force_q || !cur_valid || (cur_cache != seg);
        wr_addr    = BaseAddr + AddrStride * 32'(idx_q);
        last_idx   = (idx_q == LastIdx);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= BaseAddr;
            wdata_q       <= 32'h0;
            digits_q      <= '0;
            blank_q       <= '0;
            dp_q          <= '0;
            force_q       <= 1'b0;
            pend_digits_q <= '0;
            pend_blank_q  <= '0;
            pend_dp_q     <= '0;
            pend_force_q  <= 1'b0;
            pending_q     <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < int'(NumDigits); i++) begin
                cache_q[i] <= 8'h00;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        digits_q <= digits_i;
                        blank_q  <= blank_i;
                        dp_q     <= dp_i;
                        force_q  <= force_i;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StScan;
                    end
                end
                StScan: begin
                    if (need_write) begin
                        addr_q  <= wr_addr;
                        wdata_q <= {24'h0, seg};
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end else if (last_idx) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StWrite: begin
                    if (!avm_waitrequest_i) begin
                        write_q <= 1'b0;
                        for (int i = 0; i < int'(NumDigits); i++) begin
                            if (idx_q == IdxW'(i)) begin
                                cache_q[i] <= wdata_q[7:0];
                                valid_q[i] <= 1'b1;
                            end
                        end
                        if (last_idx) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            state_q <= StScan;
                        end
                    end
                end
                StDone: begin
                    // A start arriving in this very cycle is the newest request and wins.
                    if (start_i) begin
                        digits_q  <= digits_i;
                        blank_q   <= blank_i;
                        dp_q      <= dp_i;
                        force_q   <= force_i;
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StScan;
                    end else if (pending_q) begin
                        digits_q  <= pend_digits_q;
                        blank_q   <= pend_blank_q;
                        dp_q      <= pend_dp_q;
                        force_q   <= pend_force_q;
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StScan;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (start_i && (state_q == StScan || state_q == StWrite)) begin
                pend_digits_q <= digits_i;
                pend_blank_q  <= blank_i;
                pend_dp_q     <= dp_i;
                pend_force_q  <= force_i;
                pending_q     <= 1'b1;
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign avm_address_o    = addr_q;
    assign avm_write_o      = write_q;
    assign avm_writedata_o  = wdata_q;
    assign avm_byteenable_o = 4'b0001;

endmodule

// File: tb/tb_hex_display_master.sv
// Scoreboard bench for hex_display_master: expected writes are queued by the stimulus
// and popped by a monitor on every completed Avalon transfer.
module tb_hex_display_master;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        force_i = 1'b0;
    logic [23:0] digits_i = '0;
    logic [5:0]  blank_i = '0;
    logic [5:0]  dp_i = '0;
    logic        busy_o, done_o, avm_write_o;
    logic [31:0] avm_address_o, avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i;

    hex_display_master dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .force_i          (force_i),
        .digits_i         (digits_i),
        .blank_i          (blank_i),
        .dp_i             (dp_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .avm_address_o    (avm_address_o),
        .avm_write_o      (avm_write_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_byteenable_o (avm_byteenable_o),
        .avm_waitrequest_i(avm_waitrequest_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   exp_done = 0;
    int   stall_cnt = 0;
    bit   stall_en = 1'b0;
    bit   stall_hold = 1'b0;
    bit   prev_done_xfer = 1'b0;

    // Slave model: optionally stall the digit-2 write for five cycles, or stall forever.
    always_comb begin
        avm_waitrequest_i = avm_write_o &&
            (stall_hold || (stall_en && avm_address_o == 32'h20 && stall_cnt < 5));
    end

    always @(posedge clk_i) begin
        if (stall_en && avm_write_o && avm_address_o == 32'h20 && stall_cnt < 5) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every completed transfer against the scoreboard head.
    always @(negedge clk_i) begin
        if (done_o) done_seen++;
        if (prev_done_xfer) check("write_gap", {31'b0, avm_write_o}, 32'd0);
        prev_done_xfer = 1'b0;
        if (avm_write_o) begin
            if (sb.size() == 0) begin
                check("unexpected_write", avm_address_o, 32'hFFFF_FFFF);
            end else if (avm_waitrequest_i) begin
                check("stall_addr", avm_address_o, sb[0].addr);
                check("stall_data", avm_writedata_o, {24'h0, sb[0].data});
            end else begin
                check("wr_addr", avm_address_o, sb[0].addr);
                check("wr_data", avm_writedata_o, {24'h0, sb[0].data});
                check("wr_be", {28'h0, avm_byteenable_o}, 32'h1);
                void'(sb.pop_front());
                prev_done_xfer = 1'b1;
            end
        end
    end

    task automatic push(input logic [31:0] addr, input logic [7:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_all(input logic [47:0] codes);
        for (int i = 0; i < 6; i++) push(32'(16 * i), codes[8*i +: 8]);
    endtask

    task automatic do_start(input logic [23:0] d, input logic [5:0] b, input logic [5:0] p,
                            input logic f);
        @(posedge clk_i);
        #1;
        digits_i = d; blank_i = b; dp_i = p; force_i = f; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_hi);
        cyc = 0;
        busy_hi = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                cyc = i;
                break;
            end
            if (busy_o) busy_hi++;
        end
        if (cyc == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    int cyc, bh;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_write", {31'b0, avm_write_o}, 32'd0);
        check("rst_addr", avm_address_o, 32'h0);
        check("rst_wdata", avm_writedata_o, 32'h0);
        check("rst_be", {28'h0, avm_byteenable_o}, 32'h1);
        reset_i = 1'b0;

        // Full refresh after reset: cache invalid, all six written.
        push_all(48'h92_99_B0_A4_F9_C0);
        do_start(24'h543210, 6'b0, 6'b0, 1'b0);
        exp_done++;
        wait_done(cyc, bh);
        check("full_done_cycle", cyc, 13);
        check("full_busy_cycles", bh, 12);
        check("full_busy_at_done", {31'b0, busy_o}, 32'd0);

        // Identical request: nothing written.
        do_start(24'h543210, 6'b0, 6'b0, 1'b0);
        exp_done++;
        wait_done(cyc, bh);
        check("clean_done_cycle", cyc, 7);

        // One digit changed.
        push(32'h00, 8'h90);
        do_start(24'h543219, 6'b0, 6'b0, 1'b0);
        exp_done++;
        wait_done(cyc, bh);
        check("one_done_cycle", cyc, 8);

        // Forced refresh with a 5-cycle stall on digit 2.
        push_all(48'h92_99_B0_A4_F9_C0);
        stall_en = 1'b1;
        do_start(24'h543210, 6'b0, 6'b0, 1'b1);
        exp_done++;
        wait_done(cyc, bh);
        check("stall_done_cycle", cyc, 18);
        check("stall_cycles", stall_cnt, 5);
        stall_en = 1'b0;

        // Blank and decimal point, forced.
        push_all(48'hC0_C0_C0_C0_FF_40);
        do_start(24'h000000, 6'b000010, 6'b000001, 1'b1);
        exp_done++;
        wait_done(cyc, bh);
        check("blank_done_cycle", cyc, 13);

        // Two starts while busy: the newer one runs after the current refresh.
        push_all(48'hC0_C0_C0_C0_C0_C0);
        push_all(48'hA4_A4_A4_A4_A4_A4);
        do_start(24'h000000, 6'b0, 6'b0, 1'b1);
        @(posedge clk_i); #1;
        digits_i = 24'h111111; force_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        digits_i = 24'h222222; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        exp_done += 2;
        wait_done(cyc, bh);
        wait_done(cyc, bh);
        check("pending_gap", cyc, 13);
        repeat (5) @(negedge clk_i);
        check("pending_done_count", done_seen, exp_done);

        // Reset while a write is stalled.
        push(32'h00, 8'hA4);
        stall_hold = 1'b1;
        do_start(24'h222222, 6'b0, 6'b0, 1'b1);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (avm_write_o) begin
                cyc = i;
                break;
            end
        end
        check("hold_write_seen", {31'b0, cyc != 0}, 32'd1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_mid_write", {31'b0, avm_write_o}, 32'd0);
        check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        reset_i = 1'b0;
        stall_hold = 1'b0;
        sb.delete();

        // Unchanged digits, but the cache was invalidated by reset.
        push_all(48'hA4_A4_A4_A4_A4_A4);
        do_start(24'h222222, 6'b0, 6'b0, 1'b0);
        exp_done++;
        wait_done(cyc, bh);
        check("post_rst_done_cycle", cyc, 13);

        repeat (5) @(negedge clk_i);
        check("sb_empty", sb.size(), 0);
        check("done_count", done_seen, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
